// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and
// default geometry of the storage array.
package ram_arb_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_RAM_WIDTH = 16;
   localparam int DEFAULT_RAM_DEPTH = 8;
   localparam int DEFAULT_ADD_SIZE  = 3;

endpackage

// File: rtl/ram_port_arbiter_sp_ram.sv
// Single-port synchronous RAM: one access per cycle, registered read data that
// holds its value until the next read.
module sp_ram
   import ram_arb_pkg::*;
#(
   parameter int RAM_WIDTH = DEFAULT_RAM_WIDTH,
   parameter int RAM_DEPTH = DEFAULT_RAM_DEPTH,
   parameter int ADD_SIZE  = DEFAULT_ADD_SIZE
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [ADD_SIZE-1:0]  add,
   input  logic [RAM_WIDTH-1:0] wdata,
   output logic [RAM_WIDTH-1:0] rdata
);

   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

   // No reset on the array; the owner clears it with an initialisation sweep.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[add] <= wdata;
         end else begin
            rdata <= mem[add];
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM, with a zeroing sweep
// after reset. Define RAM_ARB_FIXED_PRIO_EN to make port 0 always win contention.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int RAM_WIDTH = DEFAULT_RAM_WIDTH,
   parameter int RAM_DEPTH = DEFAULT_RAM_DEPTH,
   parameter int ADD_SIZE  = DEFAULT_ADD_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [ADD_SIZE-1:0]  add0,
   input  logic [ADD_SIZE-1:0]  add1,
   input  logic [RAM_WIDTH-1:0] wdata0,
   input  logic [RAM_WIDTH-1:0] wdata1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 rvalid0,
   output logic                 rvalid1,
   output logic [RAM_WIDTH-1:0] rdata,
   output logic                 busy
);

   localparam logic [ADD_SIZE-1:0] LAST_ADD = ADD_SIZE'(RAM_DEPTH - 1);

   state_t               state;
   state_t               state_nxt;
   logic [ADD_SIZE-1:0]  init_cnt;
   logic [ADD_SIZE-1:0]  init_cnt_nxt;
   logic                 ram_en;
   logic                 ram_we;
   logic [ADD_SIZE-1:0]  ram_add;
   logic [RAM_WIDTH-1:0] ram_wdata;
   logic [RAM_WIDTH-1:0] ram_rdata;
   logic                 rd_loaded;
   logic                 win0;
   logic                 rd0;
   logic                 rd1;

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign win0 = 1'b1;
`else
   logic prio;

   // Round-robin pointer: after a contended cycle it points at the loser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (state == RUN && req0 && req1) begin
         prio <= ~prio;
      end
   end

   assign win0 = ~prio;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   // INIT owns the RAM port for the sweep; in RUN the winner's access is steered to it.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      busy         = 1'b0;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_add      = init_cnt;
      ram_wdata    = '0;
      case (state)
         INIT: begin
            busy   = 1'b1;
            ram_en = 1'b1;
            ram_we = 1'b1;
            if (init_cnt == LAST_ADD) begin
               state_nxt    = RUN;
               init_cnt_nxt = '0;
            end else begin
               init_cnt_nxt = init_cnt + 1'b1;
            end
         end
         RUN: begin
            gnt0   = req0 & (~req1 | win0);
            gnt1   = req1 & (~req0 | ~win0);
            ram_en = gnt0 | gnt1;
            if (gnt1) begin
               ram_we    = we1;
               ram_add   = add1;
               ram_wdata = wdata1;
            end else begin
               ram_we    = we0;
               ram_add   = add0;
               ram_wdata = wdata0;
            end
         end
      endcase
   end

   assign rd0 = gnt0 & ~we0;
   assign rd1 = gnt1 & ~we1;

   // rd_loaded masks the RAM's unreset read register so rdata reads zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rd_loaded <= 1'b0;
      end else begin
         rvalid0 <= rd0;
         rvalid1 <= rd1;
         if (rd0 | rd1) begin
            rd_loaded <= 1'b1;
         end
      end
   end

   assign rdata = rd_loaded ? ram_rdata : '0;

   sp_ram #(
      .RAM_WIDTH (RAM_WIDTH),
      .RAM_DEPTH (RAM_DEPTH),
      .ADD_SIZE  (ADD_SIZE)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .add   (ram_add),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized
// traffic against a memory-array reference model (honours RAM_ARB_FIXED_PRIO_EN).
module tb_ram_port_arbiter;

   localparam int W = 16;
   localparam int D = 8;
   localparam int A = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1, we0, we1;
   logic [A-1:0] add0, add1;
   logic [W-1:0] wdata0, wdata1;
   logic         gnt0, gnt1, rvalid0, rvalid1, busy;
   logic [W-1:0] rdata;

   always #5 clk = ~clk;

   ram_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADD_SIZE(A)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .add0(add0), .add1(add1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .busy(busy)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [W-1:0] mem_m [D];
   int           init_left;
   bit           prio_m;
   bit           exp_rv0, exp_rv1;
   logic [W-1:0] exp_rd;
   bit           exp_g0, exp_g1;
   bit           last_g0, last_g1, last_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelGrant();
      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
      if (init_left == 0) begin
         if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_g0 = 1'b1;
`else
            if (prio_m == 1'b0) exp_g0 = 1'b1;
            else                exp_g1 = 1'b1;
`endif
         end else begin
            exp_g0 = req0;
            exp_g1 = req1;
         end
      end
   endfunction

   function automatic void modelReset();
      init_left = D;
      for (int i = 0; i < D; i++) mem_m[i] = '0;
      prio_m  = 1'b0;
      exp_rv0 = 1'b0;
      exp_rv1 = 1'b0;
      exp_rd  = '0;
   endfunction

   function automatic void modelEdge();
      exp_rv0 = exp_g0 && !we0;
      exp_rv1 = exp_g1 && !we1;
      if (init_left > 0) begin
         init_left--;
      end else begin
         if (exp_g0) begin
            if (we0) mem_m[add0] = wdata0;
            else     exp_rd = mem_m[add0];
         end
         if (exp_g1) begin
            if (we1) mem_m[add1] = wdata1;
            else     exp_rd = mem_m[add1];
         end
`ifndef RAM_ARB_FIXED_PRIO_EN
         if (req0 && req1) prio_m = !prio_m;
`endif
      end
   endfunction

   task automatic checkOutput();
      modelGrant();
      check("gnt0",    {31'd0, gnt0},    {31'd0, exp_g0});
      check("gnt1",    {31'd0, gnt1},    {31'd0, exp_g1});
      check("busy",    {31'd0, busy},    {31'd0, init_left > 0});
      check("rvalid0", {31'd0, rvalid0}, {31'd0, exp_rv0});
      check("rvalid1", {31'd0, rvalid1}, {31'd0, exp_rv1});
      check("rdata",   {16'd0, rdata},   {16'd0, exp_rd});
   endtask

   // One clock: drive inputs after the falling edge, check, then advance the model.
   task automatic applyStimulus(input logic r0, input logic w0, input logic [A-1:0] a0,
                                input logic [W-1:0] d0, input logic r1, input logic w1,
                                input logic [A-1:0] a1, input logic [W-1:0] d1);
      req0 = r0; we0 = w0; add0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; add1 = a1; wdata1 = d1;
      #1;
      checkOutput();
      last_g0   = gnt0;
      last_g1   = gnt1;
      last_busy = busy;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
   endtask

   task automatic checkResetValues();
      check("reset_busy",    {31'd0, busy},    32'd1);
      check("reset_gnt0",    {31'd0, gnt0},    32'd0);
      check("reset_gnt1",    {31'd0, gnt1},    32'd0);
      check("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
      check("reset_rvalid1", {31'd0, rvalid1}, 32'd0);
      check("reset_rdata",   {16'd0, rdata},   32'd0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkResetValues();
      modelReset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idleSweep();
      for (int i = 0; i < D; i++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
         check("sweep_busy", {31'd0, last_busy}, 32'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      add0 = '0; add1 = '0; wdata0 = '0; wdata1 = '0;
      last_g0 = 1'b0; last_g1 = 1'b0; last_busy = 1'b0;
      @(negedge clk);
      doReset();

      // Sweep lasts exactly D cycles, then every word reads back zero
      idleSweep();
      #1;
      check("busy_after_sweep", {31'd0, busy}, 32'd0);
      for (int a = 0; a < D; a++) begin
         applyStimulus(1'b1, 1'b0, A'(a), '0, 1'b0, 1'b0, '0, '0);
         check("init_read_rvalid0", {31'd0, rvalid0}, 32'd1);
         check("init_read_rdata",   {16'd0, rdata},   32'd0);
      end

      // Write on port 0, then read the same word on port 1 the next cycle
      applyStimulus(1'b1, 1'b1, 3'd3, 16'h00A5, 1'b0, 1'b0, '0, '0);
      check("wr_gnt0", {31'd0, last_g0}, 32'd1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd3, '0);
      check("rd_gnt1",    {31'd0, last_g1}, 32'd1);
      check("rd_rvalid1", {31'd0, rvalid1}, 32'd1);
      check("rd_rvalid0", {31'd0, rvalid0}, 32'd0);
      check("rd_rdata",   {16'd0, rdata},   32'h00A5);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      check("rvalid1_pulse", {31'd0, rvalid1}, 32'd0);
      check("rdata_hold",    {16'd0, rdata},   32'h00A5);

      // Continuous contention from a fresh reset (pointer starts at port 0)
      @(negedge clk);
      doReset();
      idleSweep();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0, 3'd1, '0, 1'b1, 1'b0, 3'd2, '0);
`ifdef RAM_ARB_FIXED_PRIO_EN
         check("contend_gnt0", {31'd0, last_g0}, 32'd1);
         check("contend_gnt1", {31'd0, last_g1}, 32'd0);
`else
         check("contend_gnt0", {31'd0, last_g0}, {31'd0, (k % 2) == 0});
         check("contend_gnt1", {31'd0, last_g1}, {31'd0, (k % 2) == 1});
`endif
         check("contend_rvalid0", {31'd0, rvalid0}, {31'd0, last_g0});
         check("contend_rvalid1", {31'd0, rvalid1}, {31'd0, last_g1});
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

      // Reset in the middle of a granted write; the word must come back zero
      applyStimulus(1'b1, 1'b1, 3'd7, 16'h1234, 1'b0, 1'b0, '0, '0);
      req0 = 1'b1; we0 = 1'b1; add0 = 3'd7; wdata0 = 16'hFFFF;
      #1;
      check("abort_gnt0", {31'd0, gnt0}, 32'd1);
      #1;
      doReset();
      // Requests during the sweep are ignored; first grant on cycle 9
      for (int k = 1; k <= D + 1; k++) begin
         applyStimulus(1'b1, 1'b0, 3'd7, '0, 1'b0, 1'b0, '0, '0);
         check("init_hold_gnt0", {31'd0, last_g0}, {31'd0, k == D + 1});
      end
      check("abort_rvalid0", {31'd0, rvalid0}, 32'd1);
      check("abort_rdata",   {16'd0, rdata},   32'd0);

      // Randomized traffic; a refused requester keeps its request unchanged
      for (int n = 0; n < 500; n++) begin
         logic         r0, w0, r1, w1;
         logic [A-1:0] a0, a1;
         logic [W-1:0] d0, d1;
         if (req0 && !last_g0) begin
            r0 = req0; w0 = we0; a0 = add0; d0 = wdata0;
         end else begin
            r0 = ($urandom_range(0, 2) != 0);
            w0 = $urandom_range(0, 1) == 1;
            a0 = A'($urandom_range(0, D - 1));
            d0 = W'($urandom);
         end
         if (req1 && !last_g1) begin
            r1 = req1; w1 = we1; a1 = add1; d1 = wdata1;
         end else begin
            r1 = ($urandom_range(0, 2) != 0);
            w1 = $urandom_range(0, 1) == 1;
            a1 = A'($urandom_range(0, D - 1));
            d1 = W'($urandom);
         end
         applyStimulus(r0, w0, a0, d0, r1, w1, a1, d1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
